// File: rtl/tdm_demultiplexer.sv
// tdm_demultiplexer -- routes a serial word stream into four registered lanes.
//
// Words are collected in per-lane shadow registers. When all four lanes have
// been written the frame is handed to out0..out3 in one shot, so a consumer
// never sees a half-updated frame.
//
// Ports:
//   clk, reset            single clock, synchronous active-high reset
//   in_valid, in_data     incoming word strobe and data
//   auto                  1: internal slot counter picks the lane
//                         0: {address0,address1} picks the lane
//   address0, address1    manual lane select (address0 is the MSB)
//   out_ready             consumer accepts the presented frame
//   out0..out3            registered frame lanes
//   out_valid             out0..out3 hold a complete, unconsumed frame
//   slot                  lane the auto counter writes next
//   overflow              sticky: a completed frame was dropped

// One lane: shadow word, written flag and presented output word.
module tdm_demux_lane #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr,     // capture din into the shadow word
  input  logic             clr,    // clear the written flag
  input  logic             load,   // move the frame to the output
  input  logic [WIDTH-1:0] din,
  output logic             written,
  output logic [WIDTH-1:0] dout
);
  logic [WIDTH-1:0] shadow;

  always_ff @(posedge clk) begin
    if (reset) begin
      shadow  <= '0;
      written <= 1'b0;
      dout    <= '0;
    end else begin
      if (wr) shadow <= din;
      if (clr)     written <= 1'b0;
      else if (wr) written <= 1'b1;
      // The completing word lands in the output directly, bypassing the
      // shadow it is being written into on the same edge.
      if (load) dout <= wr ? din : shadow;
    end
  end
endmodule

module tdm_demultiplexer #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             auto,
  input  logic             address0,
  input  logic             address1,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out0,
  output logic [WIDTH-1:0] out1,
  output logic [WIDTH-1:0] out2,
  output logic [WIDTH-1:0] out3,
  output logic             out_valid,
  output logic [1:0]       slot,
  output logic             overflow
);
  localparam int NUM_LANES = 4;

  logic                                auto_q;
  logic                                auto_chg;
  logic                                accept;
  logic [1:0]                          idx;
  logic [NUM_LANES-1:0]                wr;
  logic [NUM_LANES-1:0]                mask;
  logic                                complete;
  logic                                load;
  logic                                clr;
  logic [NUM_LANES-1:0][WIDTH-1:0]     lane_dout;

  // A mode switch restarts frame assembly and swallows that edge's word.
  assign auto_chg = auto ^ auto_q;
  assign accept   = in_valid & ~auto_chg;
  assign idx      = auto ? slot : {address0, address1};

  assign complete = accept & (&(mask | wr));
  // A finished frame is only presented if the output slot is free or being
  // consumed on this same edge; otherwise it is dropped.
  assign load     = complete & (~out_valid | out_ready);
  assign clr      = complete | auto_chg;

  genvar i;
  generate
    for (i = 0; i < NUM_LANES; i++) begin : g_lane
      assign wr[i] = accept & (idx == 2'(i));
      tdm_demux_lane #(.WIDTH(WIDTH)) u_lane (
        .clk     (clk),
        .reset   (reset),
        .wr      (wr[i]),
        .clr     (clr),
        .load    (load),
        .din     (in_data),
        .written (mask[i]),
        .dout    (lane_dout[i])
      );
    end
  endgenerate

  assign out0 = lane_dout[0];
  assign out1 = lane_dout[1];
  assign out2 = lane_dout[2];
  assign out3 = lane_dout[3];

  always_ff @(posedge clk) begin
    if (reset) begin
      auto_q    <= 1'b0;
      slot      <= 2'd0;
      out_valid <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      auto_q <= auto;

      if (auto_chg || !auto) slot <= 2'd0;
      else if (accept)       slot <= slot + 2'd1;

      if (load)                        out_valid <= 1'b1;
      else if (out_valid && out_ready) out_valid <= 1'b0;

      if (complete && out_valid && !out_ready) overflow <= 1'b1;
    end
  end
endmodule

// File: tb/tb_tdm_demultiplexer.sv
// Scoreboard bench for tdm_demultiplexer (WIDTH=1). Stimulus pushes the
// expected frame {out0,out1,out2,out3} whenever it issues a completing word;
// the monitor pops on every newly presented frame and checks that held frames
// stay stable.
module tb_tdm_demultiplexer;
  logic       clk = 1'b0;
  logic       reset, in_valid, auto, address0, address1, out_ready;
  logic [0:0] in_data;
  logic [0:0] out0, out1, out2, out3;
  logic       out_valid, overflow;
  logic [1:0] slot;

  int n_chk  = 0;
  int n_fail = 0;
  logic [3:0] exp_q[$];

  tdm_demultiplexer #(.WIDTH(1)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .auto(auto), .address0(address0), .address1(address1),
    .out_ready(out_ready), .out0(out0), .out1(out1), .out2(out2), .out3(out3),
    .out_valid(out_valid), .slot(slot), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, wait for the edge, settle.
  task automatic step(input logic iv, input logic d, input logic au,
                      input logic a0, input logic a1, input logic rdy);
    in_valid = iv; in_data = d; auto = au;
    address0 = a0; address1 = a1; out_ready = rdy;
    @(posedge clk); #1;
  endtask

  // Auto-mode word with out_ready choice.
  task automatic aw(input logic d, input logic rdy);
    step(1'b1, d, 1'b1, 1'b0, 1'b0, rdy);
  endtask

  // Monitor: a frame is new if the previous cycle did not hold an
  // unconsumed frame.
  logic       fresh = 1'b1;
  logic [3:0] last  = '0;
  always @(negedge clk) begin
    if (reset) begin
      fresh = 1'b1;
    end else if (out_valid) begin
      if (fresh) begin
        if (exp_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL frame_unexpected: got %b with empty queue at %0t",
                   {out0, out1, out2, out3}, $time);
        end else begin
          chk("frame", int'({out0, out1, out2, out3}), int'(exp_q.pop_front()));
        end
      end else begin
        chk("frame_held", int'({out0, out1, out2, out3}), int'(last));
      end
      last  = {out0, out1, out2, out3};
      fresh = out_ready;
    end else begin
      fresh = 1'b1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    chk("rst_valid", out_valid, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_slot", slot, 0);
    chk("rst_lanes", int'({out0, out1, out2, out3}), 0);

    // Auto stream 1,0,1,1 with slot sequence 1,2,3,0.
    step(0, 0, 1, 0, 0, 1);              // mode change edge
    chk("slot_after_chg", slot, 0);
    aw(1, 1); chk("slot1", slot, 1);
    aw(0, 1); chk("slot2", slot, 2);
    aw(1, 1); chk("slot3", slot, 3); chk("no_early_valid", out_valid, 0);
    exp_q.push_back(4'b1011);
    aw(1, 1); chk("slot0", slot, 0); chk("valid_after_4", out_valid, 1);
    step(0, 0, 1, 0, 0, 1);
    chk("valid_one_cycle", out_valid, 0);

    // Manual: lanes 3,1,1,0,2 data 1,0,1,0,1.
    step(0, 0, 0, 0, 0, 1);              // mode change edge
    step(1, 1, 0, 1, 1, 1);
    step(1, 0, 0, 0, 1, 1);
    step(1, 1, 0, 0, 1, 1);
    step(1, 0, 0, 0, 0, 1);
    chk("man_no_valid", out_valid, 0);
    chk("man_slot", slot, 0);
    exp_q.push_back(4'b0111);
    step(1, 1, 0, 1, 0, 1);
    chk("man_valid", out_valid, 1);
    step(0, 0, 0, 0, 0, 1);

    // Overflow: frame A held with out_ready=0, frame B dropped.
    step(0, 0, 1, 0, 0, 0);              // mode change edge
    exp_q.push_back(4'b1111);
    aw(1, 0); aw(1, 0); aw(1, 0); aw(1, 0);
    chk("ovf_clear_before", overflow, 0);
    aw(0, 0); aw(0, 0); aw(0, 0); aw(0, 0);
    chk("ovf_set", overflow, 1);
    chk("ovf_valid_held", out_valid, 1);
    chk("ovf_lanes", int'({out0, out1, out2, out3}), 4'b1111);
    step(0, 0, 1, 0, 0, 1);              // consume A
    chk("ovf_consumed", out_valid, 0);
    chk("ovf_sticky", overflow, 1);
    chk("ovf_lanes_retain", int'({out0, out1, out2, out3}), 4'b1111);

    // Back-to-back after a fresh reset.
    reset = 1'b1; step(0, 0, 1, 0, 0, 1); reset = 1'b0;
    chk("rst2_ovf", overflow, 0);
    step(0, 0, 1, 0, 0, 1);              // mode change edge
    aw(0, 1); aw(1, 1); aw(0, 1);
    exp_q.push_back(4'b0101);
    aw(1, 1);
    chk("b2b_v1", out_valid, 1);
    aw(1, 1); aw(1, 1); aw(0, 1);
    exp_q.push_back(4'b1100);
    aw(0, 1);
    chk("b2b_v2", out_valid, 1);
    chk("b2b_ovf", overflow, 0);
    step(0, 0, 1, 0, 0, 1);

    // Partial frame discarded by an auto toggle; toggle-edge words ignored.
    aw(1, 1); aw(1, 1);
    step(1, 1, 0, 0, 0, 1);
    step(1, 1, 1, 0, 0, 1);
    chk("toggle_slot", slot, 0);
    chk("toggle_no_valid", out_valid, 0);
    aw(1, 1); aw(0, 1); aw(0, 1);
    exp_q.push_back(4'b1001);
    aw(1, 1);
    step(0, 0, 1, 0, 0, 1);

    // Reset mid-frame while a frame is held.
    exp_q.push_back(4'b1010);
    aw(1, 0); aw(0, 0); aw(1, 0); aw(0, 0);
    aw(1, 0); aw(1, 0); aw(1, 0);
    chk("pre_rst_valid", out_valid, 1);
    reset = 1'b1; step(1, 1, 1, 0, 0, 1); reset = 1'b0;
    chk("rst3_valid", out_valid, 0);
    chk("rst3_lanes", int'({out0, out1, out2, out3}), 0);
    chk("rst3_slot", slot, 0);
    step(0, 0, 1, 0, 0, 1);              // mode change edge
    aw(0, 1); aw(1, 1); aw(1, 1);
    exp_q.push_back(4'b0110);
    aw(0, 1);
    chk("rst3_fresh_valid", out_valid, 1);
    step(0, 0, 1, 0, 0, 1);
    step(0, 0, 1, 0, 0, 1);

    chk("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/tdm_demultiplexer.md
TDM_DEMULTIPLEXER -- requirements
Module: tdm_demultiplexer

Interface
REQ-001 SHALL have parameter: WIDTH, default 1, data width of in_data and each output lane.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: in_valid  input  1  in_data is presented this cycle.
REQ-005 SHALL have port: in_data  input  WIDTH  serial data word to route.
REQ-006 SHALL have port: auto  input  1  1 = internal slot counter selects lane; 0 = address pins select lane.
REQ-007 SHALL have port: address0  input  1  manual select MSB.
REQ-008 SHALL have port: address1  input  1  manual select LSB.
REQ-009 SHALL have port: out_ready  input  1  consumer accepts the current frame.
REQ-010 SHALL have ports: out0, out1, out2, out3  output  WIDTH each  registered frame lanes.
REQ-011 SHALL have port: out_valid  output  1  out0..out3 hold a complete, unconsumed frame.
REQ-012 SHALL have port: slot  output  2  next lane the auto counter will write.
REQ-013 SHALL have port: overflow  output  1  sticky flag; a completed frame was dropped.

Function
REQ-014 SHALL compute the manual lane index as 2*address0 + address1 (address0 = MSB; 00->out0, 01->out1, 10->out2, 11->out3).
REQ-015 SHALL keep four WIDTH-bit shadow registers plus a 4-bit written mask, separate from out0..out3.
REQ-016 Auto mode: on each edge with in_valid=1, SHALL write in_data to shadow[slot], set mask[slot], and advance slot by 1 modulo 4 (3 wraps to 0).
REQ-017 Manual mode: on each edge with in_valid=1, SHALL write in_data to shadow[manual index] and set that mask bit; slot SHALL be held at 0.
REQ-018 Manual rewrite of an already-written lane SHALL overwrite its shadow word and leave the mask unchanged.
REQ-019 A frame completes on the edge where the write makes the mask 4'b1111.
REQ-020 Frame completion SHALL load the shadow contents, including the word written that edge, into out0..out3 and clear the mask.
REQ-021 Outputs SHALL be valid one cycle after the completing word: completing word accepted at edge N gives out_valid=1 with new lanes in cycle N+1.
REQ-022 Once set, out_valid SHALL stay 1 and out0..out3 SHALL stay stable until an edge with out_valid=1 and out_ready=1.
REQ-023 An edge with out_valid=1, out_ready=1 and no completion SHALL clear out_valid; out0..out3 SHALL retain their values.
REQ-024 Completion on the same edge as consume (out_valid=1, out_ready=1) SHALL load the new frame; out_valid SHALL remain 1 with no gap.
REQ-025 Completion while out_valid=1 and out_ready=0 SHALL drop the new frame, leave outputs unchanged, clear the mask, and set overflow.
REQ-026 overflow SHALL remain 1 until reset.
REQ-027 The block SHALL register auto each cycle.
REQ-028 A change in auto SHALL clear the mask and set slot=0 on that edge, discarding any partial frame; in_valid on that edge SHALL be ignored.
REQ-029 in_valid=0 SHALL leave the shadow registers, mask and slot unchanged.
REQ-030 out_ready SHALL be ignored while out_valid=0.

Reset
REQ-031 reset=1 at a rising edge SHALL clear out0..out3, shadow registers, mask, slot, out_valid, overflow and the registered auto to 0.
REQ-032 reset SHALL take priority over in_valid, out_ready and frame completion on the same edge.
REQ-033 reset asserted mid-frame SHALL discard the partial frame; the first write after release goes to lane 0 in auto mode.

Verification
REQ-034 Auto mode, WIDTH=1, out_ready=1: stream 1,0,1,1 on consecutive cycles -> cycle after 4th word: out0..3 = 1,0,1,1; out_valid=1 for one cycle; slot sequence 1,2,3,0.
REQ-035 Manual mode: write lanes 3,1,1,0,2 with data 1,0,1,0,1 -> completes on 5th write; out0..3 = 0,1,1,1; no earlier out_valid.
REQ-036 out_ready=0: complete frame A (1,1,1,1), then frame B (0,0,0,0) -> outputs stay 1,1,1,1, out_valid stays 1, overflow=1; overflow stays 1 after out_ready=1 consumes A.
REQ-037 Back-to-back: out_ready=1, stream 8 words continuously (0,1,0,1 then 1,1,0,0) -> out_valid high in both frame cycles, lanes change 0,1,0,1 -> 1,1,0,0, overflow=0.
REQ-038 Auto mode: after 2 words, toggle auto to 0 then back to 1, then stream 4 words 1,0,0,1 -> out0..3 = 1,0,0,1; the earlier partial frame never appears.
REQ-039 Assert reset after 3 auto words while out_valid=1 -> next cycle all outputs 0, slot=0; next 4 words form a fresh frame.
